tlb_miss_arbiter: RTL

TLB_MISS_ARBITER -- requirements
Module: tlb_miss_arbiter

---
 rtl/config_pkg.sv | 13 +
 rtl/mmu_pkg.sv | 49 ++++
 rtl/tlb_miss_arbiter_rr_arb2.sv | 27 ++
 rtl/tlb_miss_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : config_pkg
// Description : Core-wide address and ASID widths shared by the MMU blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package config_pkg;

    localparam int unsigned VLEN       = 39;
    localparam int unsigned ASID_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmu_pkg
// Description : MMU shared types: PTE, TLB refill record, miss-arbiter FSM
//               state and requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package mmu_pkg;

    import config_pkg::*;

    typedef struct packed {
        logic [9:0]  reserved;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } riscv_pte_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_2M;
        logic                  is_1G;
        logic [VLEN-13:0]      vpn;
        logic [ASID_WIDTH-1:0] asid;
        riscv_pte_t            content;
    } tlb_update_cva6_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    // Bit position of each requester in the arbiter request/grant vectors
    typedef enum logic {
        REQ_ITLB = 1'b0,
        REQ_DTLB = 1'b1
    } req_id_e;

endpackage
`default_nettype wire

// File: rtl/tlb_miss_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter; on conflict the requester that
//               was not granted last wins. Grant is one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mmu_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_e    i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_last == REQ_DTLB) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tlb_miss_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tlb_miss_arbiter
// Description : Funnels ITLB/DTLB misses into a single page-table walker,
//               one walk at a time, with flush kill and walk timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_miss_arbiter
    import config_pkg::*;
    import mmu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,

    input  logic                  itlb_miss_i,
    input  logic [VLEN-1:0]       itlb_vaddr_i,
    input  logic [ASID_WIDTH-1:0] itlb_asid_i,
    output logic                  itlb_gnt_o,
    output tlb_update_cva6_t      itlb_update_o,
    output logic                  itlb_err_o,

    input  logic                  dtlb_miss_i,
    input  logic [VLEN-1:0]       dtlb_vaddr_i,
    input  logic [ASID_WIDTH-1:0] dtlb_asid_i,
    output logic                  dtlb_gnt_o,
    output tlb_update_cva6_t      dtlb_update_o,
    output logic                  dtlb_err_o,

    output logic                  ptw_req_valid_o,
    input  logic                  ptw_req_ready_i,
    output logic [VLEN-1:0]       ptw_vaddr_o,
    output logic [ASID_WIDTH-1:0] ptw_asid_o,
    input  logic                  ptw_done_i,
    input  tlb_update_cva6_t      ptw_update_i,
    input  logic                  ptw_error_i,

    output logic                  busy_o
);

    localparam int unsigned c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e            r_state,  w_state_nxt;
    req_id_e               r_winner, w_winner_nxt;
    req_id_e               r_last,   w_last_nxt;
    logic [VLEN-1:0]       r_vaddr,  w_vaddr_nxt;
    logic [ASID_WIDTH-1:0] r_asid,   w_asid_nxt;
    logic                  r_kill,   w_kill_nxt;
    logic [c_CNT_W-1:0]    r_cnt,    w_cnt_nxt;
    tlb_update_cva6_t      r_update, w_update_nxt;
    logic                  r_error,  w_error_nxt;

    logic [1:0]            w_arb_gnt;
    req_id_e               w_arb_sel;
    logic                  w_grant;
    logic                  w_fire;

    rr_arb2 u_rr_arb2 (
        .i_req  ({dtlb_miss_i, itlb_miss_i}),
        .i_last (r_last),
        .o_gnt  (w_arb_gnt)
    );

    assign w_arb_sel = w_arb_gnt[REQ_DTLB] ? REQ_DTLB : REQ_ITLB;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_winner <= REQ_ITLB;
            r_last   <= REQ_ITLB;
            r_vaddr  <= '0;
            r_asid   <= '0;
            r_kill   <= 1'b0;
            r_cnt    <= '0;
            r_update <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_winner <= w_winner_nxt;
            r_last   <= w_last_nxt;
            r_vaddr  <= w_vaddr_nxt;
            r_asid   <= w_asid_nxt;
            r_kill   <= w_kill_nxt;
            r_cnt    <= w_cnt_nxt;
            r_update <= w_update_nxt;
            r_error  <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_winner_nxt = r_winner;
        w_last_nxt   = r_last;
        w_vaddr_nxt  = r_vaddr;
        w_asid_nxt   = r_asid;
        w_kill_nxt   = r_kill;
        w_cnt_nxt    = r_cnt;
        w_update_nxt = r_update;
        w_error_nxt  = r_error;
        w_grant      = 1'b0;
        w_fire       = 1'b0;

        case (r_state)
            IDLE: begin
                if ((itlb_miss_i || dtlb_miss_i) && !flush_i) begin
                    w_winner_nxt = w_arb_sel;
                    w_vaddr_nxt  = (w_arb_sel == REQ_DTLB) ? dtlb_vaddr_i : itlb_vaddr_i;
                    w_asid_nxt   = (w_arb_sel == REQ_DTLB) ? dtlb_asid_i  : itlb_asid_i;
                    w_kill_nxt   = 1'b0;
                    w_state_nxt  = REQ;
                end
            end

            REQ: begin
                // A handshake that completes under flush still commits the
                // walker, so accept it and discard the result later.
                if (ptw_req_ready_i) begin
                    w_grant     = 1'b1;
                    w_last_nxt  = r_winner;
                    w_kill_nxt  = flush_i;
                    w_cnt_nxt   = '0;
                    w_state_nxt = WAIT;
                end else if (flush_i) begin
                    w_state_nxt = IDLE;
                end
            end

            WAIT: begin
                if (ptw_done_i) begin
                    if (r_kill || flush_i) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_update_nxt = ptw_update_i;
                        w_error_nxt  = ptw_error_i;
                        w_state_nxt  = RESP;
                    end
                end else if (r_cnt == c_CNT_MAX) begin
                    if (r_kill || flush_i) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_update_nxt = '0;
                        w_error_nxt  = 1'b1;
                        w_state_nxt  = RESP;
                    end
                end else begin
                    w_cnt_nxt  = r_cnt + c_CNT_W'(1);
                    w_kill_nxt = r_kill || flush_i;
                end
            end

            RESP: begin
                w_fire      = !flush_i;
                w_state_nxt = IDLE;
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    assign itlb_gnt_o      = w_grant && (r_winner == REQ_ITLB);
    assign dtlb_gnt_o      = w_grant && (r_winner == REQ_DTLB);
    assign itlb_err_o      = w_fire && r_error && (r_winner == REQ_ITLB);
    assign dtlb_err_o      = w_fire && r_error && (r_winner == REQ_DTLB);
    assign ptw_req_valid_o = (r_state == REQ);
    assign ptw_vaddr_o     = r_vaddr;
    assign ptw_asid_o      = r_asid;
    assign busy_o          = (r_state != IDLE);

    // Refill payload is only exposed in its valid cycle; zero otherwise.
    always_comb begin
        itlb_update_o = '0;
        dtlb_update_o = '0;
        if (w_fire && !r_error) begin
            if (r_winner == REQ_ITLB) begin
                itlb_update_o       = r_update;
                itlb_update_o.valid = 1'b1;
            end else begin
                dtlb_update_o       = r_update;
                dtlb_update_o.valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
